intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl_pkg.sv | 12 +
 rtl/intr_ctrl_if.sv | 29 ++
 rtl/intr_sync.sv | 25 ++
 rtl/intr_ctrl.sv | 93 +++++++++
 tb/tb_intr_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/intr_ctrl_pkg.sv
// rtl/intr_ctrl_pkg.sv - shared constants and FSM state type for the interrupt controller
package intr_ctrl_pkg;

  localparam int N_SRC_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/intr_ctrl_if.sv
// rtl/intr_ctrl_if.sv - interrupt lines, mask write and control-unit handshake bundle
interface intr_ctrl_if
  import intr_ctrl_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
);

  localparam int IDW = $clog2(N_SRC);

  logic [N_SRC-1:0] intr_in;
  logic             ie;
  logic             mask_we;
  logic [N_SRC-1:0] mask_din;
  logic             int_ack;
  logic             int_req;
  logic [IDW-1:0]   int_id;
  logic [N_SRC-1:0] pend;

  modport master (
    output intr_in, ie, mask_we, mask_din, int_ack,
    input  int_req, int_id, pend
  );

  modport slave (
    input  intr_in, ie, mask_we, mask_din, int_ack,
    output int_req, int_id, pend
  );

endinterface

// File: rtl/intr_sync.sv
// rtl/intr_sync.sv - two-flop synchronizer with rising-edge detect for one interrupt line
module intr_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - pending/mask registers, priority pick and request/service FSM
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  intr_ctrl_if.slave  bus
);

  localparam int IDW = $clog2(N_SRC);

  state_e           state_q, state_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] rise, elig, clr;
  logic [IDW-1:0]   id_q, id_d, low_id;
  logic             ie_low_q, ie_low_d;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    intr_sync u_sync (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .async_i (bus.intr_in[g]),
      .rise_o  (rise[g])
    );
  end

  assign elig = pend_q & mask_q;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    low_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) low_id = IDW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    ie_low_d = ie_low_q;
    clr      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.ie && (|elig)) begin
          state_d = ST_REQ;
          id_d    = low_id;
        end
      end
      ST_REQ: begin
        if (bus.int_ack) begin
          clr[id_q] = 1'b1;
          state_d   = ST_SERVICE;
          ie_low_d  = 1'b0;
        end else if (!bus.ie) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (!bus.ie) ie_low_d = 1'b1;
        else if (ie_low_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A fresh edge on the source being acknowledged must survive the clear.
  assign pend_d = (pend_q & ~clr) | rise;
  assign mask_d = bus.mask_we ? bus.mask_din : mask_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      pend_q   <= '0;
      mask_q   <= '1;
      ie_low_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      ie_low_q <= ie_low_d;
    end
  end

  assign bus.int_req = (state_q == ST_REQ);
  assign bus.int_id  = id_q;
  assign bus.pend    = pend_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb/tb_intr_ctrl.sv - scoreboard bench for intr_ctrl against a behavioural reference model
module tb_intr_ctrl;

  localparam int N   = 4;
  localparam int IDW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  intr_ctrl_if #(.N_SRC(N)) bus ();

  intr_ctrl #(.N_SRC(N)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic           req;
    logic [IDW-1:0] id;
    logic [N-1:0]   pend;
  } obs_t;

  obs_t exp_q[$];

  // Reference model: pending set, mask, who is being requested, and a
  // short history of sampled input levels standing in for the synchronizer.
  localparam int M_IDLE = 0, M_REQ = 1, M_SVC = 2;
  int             m_phase;
  logic [IDW-1:0] m_id;
  logic [N-1:0]   m_pend, m_mask, h1, h2, h3, m_edges;
  logic           m_low;

  function automatic logic [IDW-1:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return IDW'(i);
    return '0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = M_IDLE; m_id = '0; m_pend = '0; m_mask = '1; m_low = 1'b0;
      h1 = '0; h2 = '0; h3 = '0;
    end else begin
      m_edges = h2 & ~h3;
      if (m_phase == M_IDLE) begin
        if (bus.ie && ((m_pend & m_mask) != 0)) begin
          m_id = lowest(m_pend & m_mask);
          m_phase = M_REQ;
        end
      end else if (m_phase == M_REQ) begin
        if (bus.int_ack) begin
          m_pend[m_id] = 1'b0; m_phase = M_SVC; m_low = 1'b0;
        end else if (!bus.ie) begin
          m_phase = M_IDLE;
        end
      end else begin
        if (!bus.ie) m_low = 1'b1;
        else if (m_low) m_phase = M_IDLE;
      end
      m_pend = m_pend | m_edges;
      if (bus.mask_we) m_mask = bus.mask_din;
      h3 = h2; h2 = h1; h1 = bus.intr_in;
    end
    exp_q.push_back('{req: (m_phase == M_REQ), id: m_id, pend: m_pend});
  end

  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      a = '{req: bus.int_req, id: bus.int_id, pend: bus.pend};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t act=%b", $time, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t act req=%b id=%0d pend=%b exp req=%b id=%0d pend=%b",
                   $time, a.req, a.id, a.pend, e.req, e.id, e.pend);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_and_retie();
    bus.int_ack = 1'b1; cyc(1);
    bus.int_ack = 1'b0; bus.ie = 1'b0; cyc(1);
    bus.ie = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; bus.intr_in = '0; bus.ie = 1'b0; bus.mask_we = 1'b0;
    bus.mask_din = '1; bus.int_ack = 1'b0;
    cyc(2);
    chk("reset_state", {bus.int_req, bus.int_id, bus.pend}, '0);
    rst_n = 1'b1;

    // single source with latency
    bus.ie = 1'b1; bus.intr_in = 4'b0001;
    cyc(3);
    chk("single_pend", bus.pend, 4'b0001);
    chk("single_noreq_yet", bus.int_req, 1'b0);
    cyc(1);
    chk("single_req", {bus.int_req, bus.int_id}, 3'b100);
    bus.int_ack = 1'b1; cyc(1); bus.int_ack = 1'b0;
    chk("single_ack_pend", {bus.int_req, bus.pend}, 5'b00000);
    bus.ie = 1'b0; cyc(1); bus.ie = 1'b1; bus.intr_in = '0; cyc(2);

    // priority between two same-cycle sources
    bus.intr_in = 4'b1010; cyc(4);
    chk("prio_first", {bus.int_req, bus.int_id}, 3'b101);
    ack_and_retie(); cyc(2);
    chk("prio_second", {bus.int_req, bus.int_id}, 3'b111);
    ack_and_retie(); bus.intr_in = '0; cyc(2);

    // masked source accumulates but does not request
    bus.mask_we = 1'b1; bus.mask_din = 4'b1110; cyc(1); bus.mask_we = 1'b0;
    bus.intr_in = 4'b0001; cyc(5);
    chk("mask_pend", {bus.int_req, bus.pend}, 5'b00001);
    bus.mask_we = 1'b1; bus.mask_din = 4'b1111; cyc(1); bus.mask_we = 1'b0; cyc(1);
    chk("unmask_req", {bus.int_req, bus.int_id}, 3'b100);

    // IE drop withdraws request, pending retained
    bus.ie = 1'b0; cyc(1);
    chk("iedrop_req", {bus.int_req, bus.pend}, 5'b00001);
    bus.ie = 1'b1; cyc(1);
    chk("iedrop_rereq", {bus.int_req, bus.int_id}, 3'b100);
    ack_and_retie(); bus.intr_in = '0; cyc(2);

    // new edge on source 2 coincident with its acknowledge
    bus.intr_in = 4'b0100; cyc(1); bus.intr_in = '0; cyc(3);
    chk("coll_req", {bus.int_req, bus.int_id}, 3'b110);
    bus.intr_in = 4'b0100; cyc(2);
    bus.int_ack = 1'b1; cyc(1); bus.int_ack = 1'b0;
    chk("coll_pend2", bus.pend[2], 1'b1);

    // reset during REQ with 0110 pending; then a level held through reset
    bus.intr_in = 4'b0010; cyc(1); bus.ie = 1'b0; cyc(1); bus.ie = 1'b1; cyc(4);
    chk("pre_reset_req", {bus.int_req, bus.pend}, 5'b10110);
    rst_n = 1'b0; bus.intr_in = 4'b0001; cyc(1);
    chk("mid_req_reset", {bus.int_req, bus.int_id, bus.pend}, '0);
    cyc(1); rst_n = 1'b1; cyc(4);
    chk("level_at_release", {bus.int_req, bus.int_id, bus.pend}, 7'b1000001);
    bus.int_ack = 1'b1; cyc(1); bus.int_ack = 1'b0; cyc(4);
    chk("single_event", bus.pend, 4'b0000);
    bus.ie = 1'b0; cyc(1); bus.ie = 1'b1; bus.intr_in = '0; cyc(2);

    // randomized traffic, checked by the scoreboard every cycle
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 3) == 0) bus.intr_in = N'($urandom);
      bus.ie = ($urandom_range(0, 7) != 0);
      bus.int_ack = bus.int_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      bus.mask_we = ($urandom_range(0, 19) == 0);
      bus.mask_din = N'($urandom);
      cyc(1);
    end
    rst_n = 1'b1; bus.int_ack = 1'b0; bus.mask_we = 1'b0;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
